// File: rtl/decision_tree_loader_pkg.sv
// Shared constants, field layout and encodings for the decision tree node
// table. The tree walker imports this too so both sides agree on the record.
package decision_tree_loader_pkg;

    localparam int DATA_W = 8;
    localparam int REC_W  = 22;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    localparam logic [DATA_W-1:0] HDR_WRITE = 8'hA5;
    localparam logic [DATA_W-1:0] HDR_CLEAR = 8'h5A;

    // Node record layout: threshold | aux | leaf value
    localparam int THR_MSB  = 21;
    localparam int THR_LSB  = 14;
    localparam int AUX_MSB  = 13;
    localparam int AUX_LSB  = 8;
    localparam int LEAF_MSB = 7;
    localparam int LEAF_LSB = 0;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_CSUM  = 2'd1,
        ERR_INDEX = 2'd2,
        ERR_RSVD  = 2'd3
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_IDX   = 3'd1,
        ST_D2    = 3'd2,
        ST_D1    = 3'd3,
        ST_D0    = 3'd4,
        ST_CSUM  = 3'd5,
        ST_WRITE = 3'd6
    } state_e;

    // Record is {D2[5:0], D1, D0}; built field by field so the slice
    // constants above stay the single source of truth for the layout.
    function automatic logic [REC_W-1:0] make_record(
        input logic [5:0]        d2_low,
        input logic [DATA_W-1:0] d1,
        input logic [DATA_W-1:0] d0
    );
        logic [REC_W-1:0] rec;
        rec = '0;
        rec[LEAF_MSB:LEAF_LSB] = d0;
        rec[AUX_MSB:AUX_LSB]   = d1[5:0];
        rec[THR_MSB:THR_LSB]   = {d2_low, d1[7:6]};
        return rec;
    endfunction

    function automatic logic [DATA_W-1:0] frame_csum(
        input logic [DATA_W-1:0] idx,
        input logic [DATA_W-1:0] d2,
        input logic [DATA_W-1:0] d1,
        input logic [DATA_W-1:0] d0
    );
        return idx ^ d2 ^ d1 ^ d0;
    endfunction

endpackage

// File: rtl/decision_tree_loader_if.sv
// Valid/ready byte stream feeding the node table loader.
interface decision_tree_loader_if;
    import decision_tree_loader_pkg::*;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/decision_tree_loader_table_ram.sv
// Node table storage: one synchronous write port, one combinational read
// port. Contents are deliberately not reset; loaded_mask qualifies them.
module decision_tree_table_ram
    import decision_tree_loader_pkg::*;
(
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [REC_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [REC_W-1:0]  rdata
);
    logic [REC_W-1:0] mem [DEPTH];

    // Write port; a same-cycle read still sees the old entry
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/decision_tree_loader.sv
// Framed byte-stream writer for the decision tree node table. Parses
// A5 IDX D2 D1 D0 CSUM frames, validates them, writes the record and
// tracks which nodes are loaded.
module decision_tree_loader
    import decision_tree_loader_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    decision_tree_loader_if.slave stream,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [REC_W-1:0]      rd_data,
    output logic                  table_valid,
    output logic [DEPTH-1:0]      loaded_mask,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic [1:0]            err_code
);
    state_e            state, state_next;
    logic [DATA_W-1:0] idx_q, d2_q, d1_q, d0_q;
    logic              accept, clear_cmd, check_fail, write_en;
    err_e              err_sel;
    logic [DEPTH-1:0]  mask_set;

    // The only stall is the single WRITE cycle
    assign stream.in_ready = (state != ST_WRITE);
    assign accept          = stream.in_valid && stream.in_ready;
    assign clear_cmd       = accept && (state == ST_IDLE) && (stream.in_data == HDR_CLEAR);
    assign check_fail      = accept && (state == ST_CSUM) && (err_sel != ERR_NONE);
    assign write_en        = (state == ST_WRITE);
    assign mask_set        = loaded_mask | (DEPTH'(1) << idx_q[ADDR_W-1:0]);

    // Frame checks on the incoming CSUM byte: checksum, then index, then reserved bits
    always_comb begin
        err_sel = ERR_NONE;
        if (stream.in_data != frame_csum(idx_q, d2_q, d1_q, d0_q))
            err_sel = ERR_CSUM;
        else if (idx_q[DATA_W-1:ADDR_W] != '0)
            err_sel = ERR_INDEX;
        else if (d2_q[7:6] != 2'b00)
            err_sel = ERR_RSVD;
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state: one accepted byte per payload state; a clear byte stays in IDLE
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept && stream.in_data == HDR_WRITE) state_next = ST_IDX;
            ST_IDX:   if (accept) state_next = ST_D2;
            ST_D2:    if (accept) state_next = ST_D1;
            ST_D1:    if (accept) state_next = ST_D0;
            ST_D0:    if (accept) state_next = ST_CSUM;
            ST_CSUM:  if (accept) state_next = (err_sel == ERR_NONE) ? ST_WRITE : ST_IDLE;
            ST_WRITE: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Capture payload bytes as they arrive
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
            d2_q  <= '0;
            d1_q  <= '0;
            d0_q  <= '0;
        end else if (accept) begin
            case (state)
                ST_IDX:  idx_q <= stream.in_data;
                ST_D2:   d2_q  <= stream.in_data;
                ST_D1:   d1_q  <= stream.in_data;
                ST_D0:   d0_q  <= stream.in_data;
                default: ;
            endcase
        end
    end

    // Status: mask, table_valid, one-cycle pulses and sticky error code
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            loaded_mask <= '0;
            table_valid <= 1'b0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            if (write_en) begin
                loaded_mask <= mask_set;
                table_valid <= &mask_set;
                frame_ok    <= 1'b1;
                err_code    <= ERR_NONE;
            end else if (clear_cmd) begin
                loaded_mask <= '0;
                table_valid <= 1'b0;
                err_code    <= ERR_NONE;
            end else if (check_fail) begin
                frame_err <= 1'b1;
                err_code  <= err_sel;
            end
        end
    end

    decision_tree_table_ram u_table (
        .clock (clock),
        .we    (write_en),
        .waddr (idx_q[ADDR_W-1:0]),
        .wdata (make_record(d2_q[5:0], d1_q, d0_q)),
        .raddr (rd_addr),
        .rdata (rd_data)
    );
endmodule
